// File: rtl/phase_manager.sv
// phase_manager: sequences a thermometer phase-enable mask toward a requested
// active phase count, one phase per step, with a minimum dwell of whole PWM
// periods between steps. Step updates land on period boundaries; a fault input
// zeroes the mask immediately and latches until explicitly cleared.
module phase_manager #(
  parameter  int PERIOD  = 128,
  parameter  int NPHASES = 4,
  parameter  int DWELL   = 4,
  localparam int PW      = $clog2(NPHASES + 1),
  localparam int CW      = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               req_valid,
  input  logic [PW-1:0]      req_phases,
  output logic               req_ready,
  input  logic               fault,
  input  logic               fault_clr,
  output logic [CW-1:0]      tick_cnt,
  output logic               period_start,
  output logic [NPHASES-1:0] phase_en,
  output logic [PW-1:0]      active_phases,
  output logic               busy,
  output logic               fault_latched
);

  localparam int DCW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  localparam logic [CW-1:0]  LAST_TICK = CW'(PERIOD - 1);
  localparam logic [PW-1:0]  MAX_PH    = PW'(NPHASES);
  localparam logic [DCW-1:0] DWELL_LD  = DCW'(DWELL);
  localparam logic [DCW-1:0] DCNT_ONE  = DCW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DWELL,
    S_FAULT
  } state_t;

  state_t             state;
  logic [PW-1:0]      target;
  logic [DCW-1:0]     dcnt;

  logic               accept;
  logic [PW-1:0]      req_clamped;
  logic               step_up;
  logic [PW-1:0]      step_cnt;
  logic [NPHASES-1:0] step_mask;
  logic               step_done;

  assign period_start = en && (tick_cnt == LAST_TICK);
  assign req_ready    = (state == S_IDLE) && !fault;
  assign accept       = req_valid && req_ready && en;

  // Clamp an oversized request to the number of phases actually present
  always_comb begin
    req_clamped = req_phases;
    if (req_phases > MAX_PH) begin
      req_clamped = MAX_PH;
    end
  end

  // Next single step toward target: thermometer mask of the new count, so
  // exactly one bit (the top active or first inactive) changes per step
  always_comb begin
    step_up   = (target > active_phases);
    step_cnt  = step_up ? (active_phases + 1'b1) : (active_phases - 1'b1);
    step_mask = '0;
    for (int unsigned k = 0; k < NPHASES; k++) begin
      step_mask[k] = (PW'(k) < step_cnt);
    end
    step_done = (step_cnt == target);
  end

  // Tick counter plus the sequencing FSM; fault overrides everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      state         <= S_IDLE;
      target        <= '0;
      dcnt          <= '0;
      phase_en      <= '0;
      active_phases <= '0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      if (en) begin
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : (tick_cnt + 1'b1);
      end

      if (fault) begin
        state         <= S_FAULT;
        target        <= '0;
        dcnt          <= '0;
        phase_en      <= '0;
        active_phases <= '0;
        busy          <= 1'b0;
        fault_latched <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              target <= req_clamped;
              if (req_clamped != active_phases) begin
                state <= S_STEP;
                busy  <= 1'b1;
              end
            end
          end

          S_STEP: begin
            if (period_start) begin
              phase_en      <= step_mask;
              active_phases <= step_cnt;
              dcnt          <= DWELL_LD;
              if (step_done) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_DWELL;
              end
            end
          end

          S_DWELL: begin
            if (period_start) begin
              if (dcnt == DCNT_ONE) begin
                phase_en      <= step_mask;
                active_phases <= step_cnt;
                dcnt          <= DWELL_LD;
                if (step_done) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                dcnt <= dcnt - 1'b1;
              end
            end
          end

          S_FAULT: begin
            // Leaving FAULT is a state change, so it is held off while en is low
            if (en && fault_clr) begin
              state         <= S_IDLE;
              fault_latched <= 1'b0;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_manager.sv
// Bench for phase_manager with PERIOD=8, NPHASES=4, DWELL=2. A timing model
// pushes expected mask updates (value plus enabled-tick timestamp) into a
// scoreboard on request acceptance; a monitor pops them as phase_en changes.
module tb_phase_manager;

  localparam int TP  = 8;
  localparam int TN  = 4;
  localparam int TD  = 2;
  localparam int TPW = $clog2(TN + 1);
  localparam int TCW = $clog2(TP);

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           req_valid;
  logic [TPW-1:0] req_phases;
  logic           req_ready;
  logic           fault;
  logic           fault_clr;
  logic [TCW-1:0] tick_cnt;
  logic           period_start;
  logic [TN-1:0]  phase_en;
  logic [TPW-1:0] active_phases;
  logic           busy;
  logic           fault_latched;

  phase_manager #(.PERIOD(TP), .NPHASES(TN), .DWELL(TD)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .req_valid     (req_valid),
    .req_phases    (req_phases),
    .req_ready     (req_ready),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .tick_cnt      (tick_cnt),
    .period_start  (period_start),
    .phase_en      (phase_en),
    .active_phases (active_phases),
    .busy          (busy),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TN-1:0] mask;
    int unsigned   due;
  } sb_t;

  sb_t sbq[$];
  sb_t msched[$];

  int checks = 0;
  int passes = 0;

  int unsigned   ecnt = 0;
  int unsigned   cyc = 0;
  int unsigned   acc_cnt = 0;
  bit            m_busy = 1'b0;
  bit            m_fault = 1'b0;
  int unsigned   m_act = 0;
  logic [TN-1:0] m_vis = '0;
  int unsigned   m_pre, m_tgt, m_first, m_i;
  sb_t           m_e;
  sb_t           mx;
  logic [TN-1:0] m_seen = '0;

  // Timing model: ecnt counts enabled edges since reset; steps are scheduled in that domain
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt    = 0;
      m_busy  = 1'b0;
      m_fault = 1'b0;
      m_act   = 0;
      m_vis   = '0;
      sbq.delete();
      msched.delete();
    end else begin
      cyc++;
      m_pre = ecnt;
      if (en) ecnt++;
      if (fault) begin
        sbq.delete();
        msched.delete();
        if (m_vis != '0) begin
          m_e.mask = '0;
          m_e.due  = ecnt;
          sbq.push_back(m_e);
        end
        m_vis   = '0;
        m_act   = 0;
        m_busy  = 1'b0;
        m_fault = 1'b1;
      end else if (m_fault) begin
        if (fault_clr && en) m_fault = 1'b0;
      end else if (m_busy) begin
        if (msched.size() != 0 && msched[0].due == ecnt) begin
          m_vis = msched[0].mask;
          void'(msched.pop_front());
        end
        if (msched.size() == 0) m_busy = 1'b0;
      end else if (en && req_valid) begin
        acc_cnt++;
        m_tgt = int'(req_phases);
        if (m_tgt > TN) m_tgt = TN;
        if (m_tgt != m_act) begin
          m_first = ((m_pre % TP) == TP - 1) ? (m_pre / TP + 2) * TP : (m_pre / TP + 1) * TP;
          m_i = 0;
          while (m_act != m_tgt) begin
            if (m_tgt > m_act) m_act++;
            else m_act--;
            m_e.mask = TN'((32'd1 << m_act) - 1);
            m_e.due  = m_first + m_i * (TP * TD);
            sbq.push_back(m_e);
            msched.push_back(m_e);
            m_i++;
          end
          m_busy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [TPW-1:0] v, input int unsigned limit);
    int unsigned a0 = acc_cnt;
    int unsigned n  = 0;
    req_valid  = 1'b1;
    req_phases = v;
    while (acc_cnt == a0 && n < limit) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((m_busy || sbq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL wait_idle: sequence still pending after %0d cycles", n);
    end
  endtask

  task automatic wait_vis(input logic [TN-1:0] m);
    int unsigned n = 0;
    while (m_vis !== m && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_phases = '0; fault = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tick_cnt !== '0) $display("FAIL reset_tick: got %0d expected 0", tick_cnt); else passes++;
    checks++; if (phase_en !== '0) $display("FAIL reset_phase_en: got %b expected 0000", phase_en); else passes++;
    checks++; if (active_phases !== '0) $display("FAIL reset_active: got %0d expected 0", active_phases); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (fault_latched !== 1'b0) $display("FAIL reset_fault_latched: got %b expected 0", fault_latched); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else passes++;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_ramp_up();
    while ((ecnt % TP) != 2) tick();
    send_req(3'd3, 50);
    wait_idle();
    checks++; if (phase_en !== 4'b0111) $display("FAIL ramp_up_mask: got %b expected 0111", phase_en); else passes++;
    checks++; if (active_phases !== 3'd3) $display("FAIL ramp_up_active: got %0d expected 3", active_phases); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL ramp_up_ready: got %b expected 1", req_ready); else passes++;
  endtask

  task automatic test_clamp_down();
    send_req(3'd4, 50);
    wait_idle();
    checks++; if (phase_en !== 4'b1111) $display("FAIL full_mask: got %b expected 1111", phase_en); else passes++;
    send_req(3'd7, 50);
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL clamp_busy: got %b expected 0", busy); else passes++;
    checks++; if (phase_en !== 4'b1111) $display("FAIL clamp_mask: got %b expected 1111", phase_en); else passes++;
    checks++; if (active_phases !== 3'd4) $display("FAIL clamp_active: got %0d expected 4", active_phases); else passes++;
    send_req(3'd1, 50);
    wait_idle();
    checks++; if (phase_en !== 4'b0001) $display("FAIL ramp_down_mask: got %b expected 0001", phase_en); else passes++;
  endtask

  task automatic test_fault();
    send_req(3'd0, 50);
    wait_idle();
    send_req(3'd4, 50);
    wait_vis(4'b0011);
    repeat (2) tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    checks++; if (phase_en !== 4'b0000) $display("FAIL fault_mask: got %b expected 0000", phase_en); else passes++;
    checks++; if (active_phases !== 3'd0) $display("FAIL fault_active: got %0d expected 0", active_phases); else passes++;
    checks++; if (fault_latched !== 1'b1) $display("FAIL fault_latched: got %b expected 1", fault_latched); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL fault_ready: got %b expected 0", req_ready); else passes++;
    repeat (3) tick();
    fault = 1'b1;
    fault_clr = 1'b1;
    tick();
    fault = 1'b0;
    checks++; if (fault_latched !== 1'b1) $display("FAIL fault_priority: got %b expected 1", fault_latched); else passes++;
    tick();
    fault_clr = 1'b0;
    checks++; if (fault_latched !== 1'b0) $display("FAIL fault_clear: got %b expected 0", fault_latched); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL fault_clear_ready: got %b expected 1", req_ready); else passes++;
    repeat (20) tick();
    checks++; if (phase_en !== 4'b0000) $display("FAIL post_clear_mask: got %b expected 0000", phase_en); else passes++;
  endtask

  task automatic test_en_gating();
    int unsigned c1, c2, n, exp_t;
    send_req(3'd3, 50);
    n = 0;
    while (phase_en === 4'b0000 && n < 100) begin tick(); n++; end
    c1 = cyc;
    checks++; if (phase_en !== 4'b0001) $display("FAIL en_first_step: got %b expected 0001", phase_en); else passes++;
    repeat (4) tick();
    en = 1'b0;
    exp_t = ecnt % TP;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (tick_cnt !== TCW'(exp_t)) $display("FAIL en_freeze_tick: got %0d expected %0d", tick_cnt, exp_t); else passes++;
      checks++; if (phase_en !== 4'b0001) $display("FAIL en_freeze_mask: got %b expected 0001", phase_en); else passes++;
    end
    en = 1'b1;
    n = 0;
    while (phase_en === 4'b0001 && n < 100) begin tick(); n++; end
    c2 = cyc;
    checks++; if (c2 - c1 !== TP * TD + 5) $display("FAIL en_step_spacing: got %0d cycles expected %0d", c2 - c1, TP * TD + 5); else passes++;
    wait_idle();
  endtask

  task automatic test_busy_reset();
    send_req(3'd0, 50);
    send_req(3'd1, 400);
    checks++; if (phase_en !== 4'b0000) $display("FAIL busy_hold_mask: got %b expected 0000", phase_en); else passes++;
    wait_idle();
    checks++; if (phase_en !== 4'b0001) $display("FAIL busy_then_mask: got %b expected 0001", phase_en); else passes++;
    send_req(3'd4, 50);
    wait_vis(4'b0011);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tick_cnt !== '0) $display("FAIL async_rst_tick: got %0d expected 0", tick_cnt); else passes++;
    checks++; if (phase_en !== '0) $display("FAIL async_rst_mask: got %b expected 0000", phase_en); else passes++;
    checks++; if (active_phases !== '0) $display("FAIL async_rst_active: got %0d expected 0", active_phases); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b expected 0", busy); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL async_rst_ready: got %b expected 1", req_ready); else passes++;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    checks++; if (phase_en !== '0) $display("FAIL post_rst_mask: got %b expected 0000", phase_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b expected 0", busy); else passes++;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          m_seen = '0;
        end else begin
          checks++; if (tick_cnt !== TCW'(ecnt % TP)) $display("FAIL mon_tick: got %0d expected %0d", tick_cnt, ecnt % TP); else passes++;
          checks++; if (period_start !== (en && (ecnt % TP) == TP - 1)) $display("FAIL mon_period_start: got %b", period_start); else passes++;
          checks++; if (busy !== m_busy) $display("FAIL mon_busy: got %b expected %b", busy, m_busy); else passes++;
          checks++; if (fault_latched !== m_fault) $display("FAIL mon_fault_latched: got %b expected %b", fault_latched, m_fault); else passes++;
          checks++; if (req_ready !== (!m_busy && !m_fault && !fault)) $display("FAIL mon_req_ready: got %b", req_ready); else passes++;
          checks++; if (active_phases !== TPW'($countones(m_vis))) $display("FAIL mon_active: got %0d expected %0d", active_phases, $countones(m_vis)); else passes++;
          if (phase_en !== m_seen) begin
            checks++;
            if (sbq.size() == 0) begin
              $display("FAIL sb_unexpected: phase_en became %b at tick %0d, none expected", phase_en, ecnt);
            end else begin
              mx = sbq.pop_front();
              if (phase_en !== mx.mask || ecnt != mx.due)
                $display("FAIL sb_step: got %b at tick %0d expected %b at tick %0d", phase_en, ecnt, mx.mask, mx.due);
              else passes++;
            end
            m_seen = phase_en;
          end else if (sbq.size() != 0 && ecnt > sbq[0].due) begin
            checks++;
            mx = sbq.pop_front();
            $display("FAIL sb_missing: phase_en stayed %b, expected %b at tick %0d", phase_en, mx.mask, mx.due);
          end
        end
      end
    join_none

    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_fault();
    test_en_gating();
    test_busy_reset();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
